// File: rtl/dram_pkg.sv
// Shared command/error encodings, refresh FSM states and width helpers
// for the DRAM device model.
package dram_pkg;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_REF = 3'b000;

    localparam logic [2:0] ERR_NONE           = 3'd0;
    localparam logic [2:0] ERR_ACT_OPEN       = 3'd1;
    localparam logic [2:0] ERR_ACCESS_CLOSED  = 3'd2;
    localparam logic [2:0] ERR_REF_OPEN       = 3'd3;
    localparam logic [2:0] ERR_CMD_DURING_REF = 3'd4;
    localparam logic [2:0] ERR_ILLEGAL        = 3'd5;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_BUSY = 2'd1,
        R_DONE = 2'd2
    } ref_state_e;

    function automatic int column_width(input int columns, input int data_width);
        return $clog2(columns / data_width);
    endfunction

    function automatic int row_width(input int rows);
        return $clog2(rows);
    endfunction

    function automatic int bank_width(input int banks);
        return $clog2(banks);
    endfunction

    function automatic int addr_width(input int row_w, input int col_w);
        return (row_w > col_w) ? row_w : col_w;
    endfunction

endpackage

// File: rtl/dram_device_model_if.sv
// DRAM command bus between controller (master) and device (slave).
// Strobes are sampled on the rising clock edge; read data and the
// refresh-done pulse come back registered from the device.
interface dram_device_model_if #(
    parameter int BANK_ID_WIDTH   = dram_pkg::bank_width(8),
    parameter int DRAM_ADDR_WIDTH = dram_pkg::addr_width(dram_pkg::row_width(128),
                                                         dram_pkg::column_width(8, 2)),
    parameter int DRAM_DATA_WIDTH = 2
);
    logic                       dram_clk_en;
    logic                       dram_cs_n;
    logic                       dram_ras_n;
    logic                       dram_cas_n;
    logic                       dram_we_n;
    logic [BANK_ID_WIDTH-1:0]   dram_bank_id;
    logic [DRAM_ADDR_WIDTH-1:0] dram_addr;
    logic [DRAM_DATA_WIDTH-1:0] dram_wr_data;
    logic [DRAM_DATA_WIDTH-1:0] dram_rd_data;
    logic                       dram_refresh_done;

    modport master (
        output dram_clk_en, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
        output dram_bank_id, dram_addr, dram_wr_data,
        input  dram_rd_data, dram_refresh_done
    );

    modport slave (
        input  dram_clk_en, dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n,
        input  dram_bank_id, dram_addr, dram_wr_data,
        output dram_rd_data, dram_refresh_done
    );
endinterface

// File: rtl/dram_refresh_timer.sv
// Refresh sequencer: IDLE -> BUSY (count down) -> DONE (one-cycle pulse).
// Everything holds while clk_en is low, so a pending pulse is only delayed.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REFRESH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       ref_cmd,
    input  logic       other_cmd,
    input  logic       all_closed,
    output logic       done,
    output logic       busy,
    output logic       busy_viol,
    output ref_state_e state
);
    localparam int             CNT_W    = $clog2(REFRESH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(REFRESH_CYCLES - 1);

    ref_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Once started the count runs every enabled cycle; stray commands are
    // flagged by the top but never stall or restart it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            R_IDLE: begin
                if (ref_cmd && all_closed) begin
                    state_d = R_BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            R_BUSY: begin
                if (cnt_q == '0) state_d = R_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            R_DONE:  state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    assign done      = (state_q == R_DONE);
    assign busy      = (state_q == R_BUSY);
    assign busy_viol = busy & other_cmd;
    assign state     = state_q;

endmodule

// File: rtl/dram_device_model.sv
// DRAM device responder: per-bank open-row tracking, storage array,
// registered reads, refresh sequencing and protocol-violation reporting.
// Optional statistics counters are built when DRAM_DEVICE_MODEL_STATS_EN is defined.
module dram_device_model
    import dram_pkg::*;
#(
    parameter int NUMBER_OF_COLUMNS = 8,
    parameter int NUMBER_OF_ROWS    = 128,
    parameter int NUMBER_OF_BANKS   = 8,
    parameter int DRAM_DATA_WIDTH   = 2,
    parameter int REFRESH_CYCLES    = 4
) (
    input  logic                u_clk,
    input  logic                u_rst_n,
    dram_device_model_if.slave  bus,
    output logic                cmd_err,
    output logic [2:0]          err_code,
    output logic [15:0]         stat_act_cnt,
    output logic [15:0]         stat_rd_cnt,
    output logic [15:0]         stat_wr_cnt,
    output logic [15:0]         stat_ref_cnt,
    output ref_state_e          dbg_ref_state
);
    localparam int COLUMN_WIDTH  = column_width(NUMBER_OF_COLUMNS, DRAM_DATA_WIDTH);
    localparam int ROW_WIDTH     = row_width(NUMBER_OF_ROWS);
    localparam int BANK_ID_WIDTH = bank_width(NUMBER_OF_BANKS);
    localparam int IDX_W         = BANK_ID_WIDTH + ROW_WIDTH + COLUMN_WIDTH;
    localparam int MEM_DEPTH     = 1 << IDX_W;

    logic [2:0]                 cmd;
    logic                       cmd_vld, is_illegal, other_cmd, all_closed;
    logic                       ref_done, ref_busy, busy_viol;
    logic [BANK_ID_WIDTH-1:0]   bank;
    logic [ROW_WIDTH-1:0]       row_in;
    logic [COLUMN_WIDTH-1:0]    col;
    logic [IDX_W-1:0]           mem_idx;

    logic [NUMBER_OF_BANKS-1:0] open_q, open_d;
    logic [ROW_WIDTH-1:0]       open_row_q [NUMBER_OF_BANKS];
    logic [ROW_WIDTH-1:0]       open_row_d [NUMBER_OF_BANKS];
    logic [DRAM_DATA_WIDTH-1:0] rd_data_q;
    logic [DRAM_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                       cmd_err_q;
    logic [2:0]                 err_code_q, err_d;
    logic                       wr_en, rd_en;

    assign cmd        = {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n};
    // The bus is ignored entirely in the cycle the done pulse is shown.
    assign cmd_vld    = bus.dram_clk_en & ~bus.dram_cs_n & ~ref_done;
    assign is_illegal = (cmd == 3'b001) || (cmd == 3'b110);
    assign other_cmd  = cmd_vld & ((cmd == CMD_ACT) || (cmd == CMD_PRE) ||
                                   (cmd == CMD_WR)  || (cmd == CMD_RD));
    assign all_closed = ~|open_q;
    assign bank       = bus.dram_bank_id;
    assign row_in     = bus.dram_addr[ROW_WIDTH-1:0];
    assign col        = bus.dram_addr[COLUMN_WIDTH-1:0];
    assign mem_idx    = {bank, open_row_q[bank], col};

    dram_refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) u_refresh (
        .clk        (u_clk),
        .rst_n      (u_rst_n),
        .clk_en     (bus.dram_clk_en),
        .ref_cmd    (cmd_vld && (cmd == CMD_REF)),
        .other_cmd  (other_cmd),
        .all_closed (all_closed),
        .done       (ref_done),
        .busy       (ref_busy),
        .busy_viol  (busy_viol),
        .state      (dbg_ref_state)
    );

    always_comb begin
        open_d     = open_q;
        open_row_d = open_row_q;
        err_d      = ERR_NONE;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        if (cmd_vld) begin
            if (is_illegal) begin
                err_d = ERR_ILLEGAL;
            end else if (busy_viol) begin
                err_d = ERR_CMD_DURING_REF;
            end else begin
                case (cmd)
                    CMD_ACT: begin
                        if (open_q[bank]) begin
                            err_d = ERR_ACT_OPEN;
                        end else begin
                            open_d[bank]     = 1'b1;
                            open_row_d[bank] = row_in;
                        end
                    end
                    CMD_PRE: open_d[bank] = 1'b0;
                    CMD_WR: begin
                        if (open_q[bank]) wr_en = 1'b1;
                        else              err_d = ERR_ACCESS_CLOSED;
                    end
                    CMD_RD: begin
                        if (open_q[bank]) rd_en = 1'b1;
                        else              err_d = ERR_ACCESS_CLOSED;
                    end
                    CMD_REF: begin
                        if (!ref_busy && !all_closed) err_d = ERR_REF_OPEN;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            open_q     <= '0;
            open_row_q <= '{default: '0};
            rd_data_q  <= '0;
            cmd_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (bus.dram_clk_en) begin
            open_q     <= open_d;
            open_row_q <= open_row_d;
            cmd_err_q  <= (err_d != ERR_NONE);
            if (err_d != ERR_NONE) err_code_q <= err_d;
            if (rd_en)             rd_data_q  <= mem_q[mem_idx];
        end
    end

    // Storage contents are deliberately not reset.
    always_ff @(posedge u_clk) begin
        if (wr_en) mem_q[mem_idx] <= bus.dram_wr_data;
    end

    assign bus.dram_rd_data      = rd_data_q;
    assign bus.dram_refresh_done = ref_done;
    assign cmd_err               = cmd_err_q;
    assign err_code              = err_code_q;

`ifdef DRAM_DEVICE_MODEL_STATS_EN
    logic [15:0] act_cnt_q, rd_cnt_q, wr_cnt_q, ref_cnt_q;
    logic        act_ok;

    assign act_ok = cmd_vld && (cmd == CMD_ACT) && (err_d == ERR_NONE);

    always_ff @(posedge u_clk or negedge u_rst_n) begin
        if (!u_rst_n) begin
            act_cnt_q <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            ref_cnt_q <= '0;
        end else if (bus.dram_clk_en) begin
            if (act_ok   && act_cnt_q != 16'hFFFF) act_cnt_q <= act_cnt_q + 16'd1;
            if (rd_en    && rd_cnt_q  != 16'hFFFF) rd_cnt_q  <= rd_cnt_q  + 16'd1;
            if (wr_en    && wr_cnt_q  != 16'hFFFF) wr_cnt_q  <= wr_cnt_q  + 16'd1;
            if (ref_done && ref_cnt_q != 16'hFFFF) ref_cnt_q <= ref_cnt_q + 16'd1;
        end
    end

    assign stat_act_cnt = act_cnt_q;
    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_ref_cnt = ref_cnt_q;
`else
    assign stat_act_cnt = '0;
    assign stat_rd_cnt  = '0;
    assign stat_wr_cnt  = '0;
    assign stat_ref_cnt = '0;
`endif

endmodule

// File: tb/tb_dram_device_model.sv
// Bench for dram_device_model: directed scenarios plus a randomized run
// checked against a transaction-level model of banks, memory and refresh.
module tb_dram_device_model;
    import dram_pkg::*;

    localparam int NB = 8, NR = 128, NC = 4, DW = 2, RC = 4;

    logic        u_clk = 1'b0;
    logic        u_rst_n = 1'b0;
    logic        cmd_err;
    logic [2:0]  err_code;
    logic [15:0] s_act, s_rd, s_wr, s_ref;
    ref_state_e  dbg_state;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 u_clk = ~u_clk;

    dram_device_model_if bus ();

    dram_device_model dut (
        .u_clk         (u_clk),
        .u_rst_n       (u_rst_n),
        .bus           (bus.slave),
        .cmd_err       (cmd_err),
        .err_code      (err_code),
        .stat_act_cnt  (s_act),
        .stat_rd_cnt   (s_rd),
        .stat_wr_cnt   (s_wr),
        .stat_ref_cnt  (s_ref),
        .dbg_ref_state (dbg_state)
    );

    // Reference model state: what the device should look like after each edge.
    bit [NB-1:0]   m_open;
    int            m_row [NB];
    logic [DW-1:0] m_mem [int];
    logic [DW-1:0] m_rd;
    bit            m_err, m_done, m_busy;
    logic [2:0]    m_code;
    int            m_left;
    int            m_stat [4];
    logic [DW-1:0] exp_q [$];

    task automatic m_reset();
        m_open = '0;
        for (int i = 0; i < NB; i++) m_row[i] = 0;
        m_rd = '0; m_err = 0; m_done = 0; m_busy = 0; m_code = ERR_NONE; m_left = 0;
        for (int i = 0; i < 4; i++) m_stat[i] = 0;
    endtask

    task automatic model_edge(input bit en, input bit cs, input logic [2:0] c,
                              input int b, input int a, input logic [DW-1:0] d);
        bit err, started;
        logic [2:0] code;
        int key;
        if (!en) return;
        err = 0; started = 0; code = ERR_NONE;
        key = (b * NR + m_row[b]) * NC + (a % NC);
        if (m_done) begin
            m_done = 0;
            if (m_stat[3] < 65535) m_stat[3]++;
        end else if (!cs && c != CMD_NOP) begin
            if (c == 3'b001 || c == 3'b110) begin
                err = 1; code = ERR_ILLEGAL;
            end else if (m_busy && c != CMD_REF) begin
                err = 1; code = ERR_CMD_DURING_REF;
            end else if (c == CMD_ACT) begin
                if (m_open[b]) begin err = 1; code = ERR_ACT_OPEN; end
                else begin
                    m_open[b] = 1; m_row[b] = a % NR;
                    if (m_stat[0] < 65535) m_stat[0]++;
                end
            end else if (c == CMD_PRE) begin
                m_open[b] = 0;
            end else if (c == CMD_WR || c == CMD_RD) begin
                if (!m_open[b]) begin err = 1; code = ERR_ACCESS_CLOSED; end
                else if (c == CMD_WR) begin
                    m_mem[key] = d;
                    if (m_stat[2] < 65535) m_stat[2]++;
                end else begin
                    if (m_stat[1] < 65535) m_stat[1]++;
                    if (m_mem.exists(key)) begin
                        m_rd = m_mem[key];
                        exp_q.push_back(m_rd);
                    end
                end
            end else if (!m_busy) begin
                if (|m_open) begin err = 1; code = ERR_REF_OPEN; end
                else begin m_busy = 1; m_left = RC; started = 1; end
            end
        end
        if (m_busy && !started) begin
            m_left--;
            if (m_left == 0) begin m_busy = 0; m_done = 1; end
        end
        m_err = err;
        if (err) m_code = code;
    endtask

    // Drive one command for one edge; returns at the following negedge.
    task automatic step(input bit en, input bit cs, input logic [2:0] c,
                        input int b, input int a, input logic [DW-1:0] d);
        bus.dram_clk_en = en;
        bus.dram_cs_n   = cs;
        {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = c;
        bus.dram_bank_id = 3'(b);
        bus.dram_addr    = 7'(a);
        bus.dram_wr_data = d;
        model_edge(en, cs, c, b, a, d);
        @(posedge u_clk);
        @(negedge u_clk);
    endtask

    task automatic nop();
        step(1, 0, CMD_NOP, 0, 0, '0);
    endtask

    task automatic test_reset();
        bus.dram_clk_en = 1; bus.dram_cs_n = 1;
        {bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = CMD_NOP;
        bus.dram_bank_id = '0; bus.dram_addr = '0; bus.dram_wr_data = '0;
        m_reset();
        @(negedge u_clk);
        chk_cnt++; if (bus.dram_rd_data !== 2'b00) $display("FAIL reset_rd: got %b exp 00", bus.dram_rd_data); else pass_cnt++;
        chk_cnt++; if ({cmd_err, err_code, bus.dram_refresh_done} !== 5'b0) $display("FAIL reset_err: got err=%b code=%0d done=%b exp 0", cmd_err, err_code, bus.dram_refresh_done); else pass_cnt++;
        chk_cnt++; if ({s_act, s_rd, s_wr, s_ref} !== 64'b0) $display("FAIL reset_stats: got %h exp 0", {s_act, s_rd, s_wr, s_ref}); else pass_cnt++;
        u_rst_n = 1;
    endtask

    task automatic test_basic_rw();
        step(1, 0, CMD_ACT, 3, 'h15, '0);
        chk_cnt++; if (cmd_err !== 1'b0) $display("FAIL basic_act_err: got %b exp 0", cmd_err); else pass_cnt++;
        step(1, 0, CMD_WR, 3, 2, 2'b10);
        chk_cnt++; if (cmd_err !== 1'b0) $display("FAIL basic_wr_err: got %b exp 0", cmd_err); else pass_cnt++;
        step(1, 0, CMD_RD, 3, 2, '0);
        chk_cnt++; if (bus.dram_rd_data !== 2'b10) $display("FAIL basic_rd: got %b exp 10", bus.dram_rd_data); else pass_cnt++;
        chk_cnt++; if (cmd_err !== 1'b0) $display("FAIL basic_rd_err: got %b exp 0", cmd_err); else pass_cnt++;
    endtask

    task automatic test_act_open();
        step(1, 0, CMD_ACT, 3, 'h20, '0);
        chk_cnt++; if ({cmd_err, err_code} !== {1'b1, ERR_ACT_OPEN}) $display("FAIL act_open: got err=%b code=%0d exp 1/1", cmd_err, err_code); else pass_cnt++;
        nop();
        chk_cnt++; if ({cmd_err, err_code} !== {1'b0, ERR_ACT_OPEN}) $display("FAIL act_open_hold: got err=%b code=%0d exp 0/1", cmd_err, err_code); else pass_cnt++;
        step(1, 0, CMD_RD, 3, 2, '0);
        chk_cnt++; if (bus.dram_rd_data !== 2'b10) $display("FAIL act_open_row: got %b exp 10", bus.dram_rd_data); else pass_cnt++;
    endtask

    task automatic test_access_closed();
        step(1, 0, CMD_RD, 5, 0, '0);
        chk_cnt++; if ({cmd_err, err_code} !== {1'b1, ERR_ACCESS_CLOSED}) $display("FAIL rd_closed: got err=%b code=%0d exp 1/2", cmd_err, err_code); else pass_cnt++;
        chk_cnt++; if (bus.dram_rd_data !== 2'b10) $display("FAIL rd_closed_data: got %b exp 10", bus.dram_rd_data); else pass_cnt++;
        step(1, 0, 3'b110, 0, 0, '0);
        chk_cnt++; if ({cmd_err, err_code} !== {1'b1, ERR_ILLEGAL}) $display("FAIL illegal: got err=%b code=%0d exp 1/5", cmd_err, err_code); else pass_cnt++;
    endtask

    task automatic test_refresh();
        step(1, 0, CMD_PRE, 3, 0, '0);
        for (int i = 1; i <= 6; i++) begin
            step(1, 0, CMD_REF, 0, 0, '0);
            chk_cnt++; if (bus.dram_refresh_done !== (i == 5)) $display("FAIL ref_done_%0d: got %b exp %b", i, bus.dram_refresh_done, (i == 5)); else pass_cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            nop();
            chk_cnt++; if ({bus.dram_refresh_done, cmd_err} !== 2'b00) $display("FAIL ref_no_restart_%0d: got done=%b err=%b exp 0", i, bus.dram_refresh_done, cmd_err); else pass_cnt++;
        end
    endtask

    task automatic test_ref_open();
        step(1, 0, CMD_ACT, 0, 1, '0);
        step(1, 0, CMD_REF, 0, 0, '0);
        chk_cnt++; if ({cmd_err, err_code} !== {1'b1, ERR_REF_OPEN}) $display("FAIL ref_open: got err=%b code=%0d exp 1/3", cmd_err, err_code); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            nop();
            chk_cnt++; if (bus.dram_refresh_done !== 1'b0) $display("FAIL ref_open_done_%0d: got %b exp 0", i, bus.dram_refresh_done); else pass_cnt++;
        end
        step(1, 0, CMD_PRE, 0, 0, '0);
        step(1, 0, CMD_REF, 0, 0, '0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 1) begin
                step(1, 0, CMD_WR, 3, 2, 2'b01);
                chk_cnt++; if ({cmd_err, err_code} !== {1'b1, ERR_CMD_DURING_REF}) $display("FAIL wr_in_ref: got err=%b code=%0d exp 1/4", cmd_err, err_code); else pass_cnt++;
            end else nop();
            chk_cnt++; if (bus.dram_refresh_done !== (i == 4)) $display("FAIL ref_after_pre_%0d: got %b exp %b", i, bus.dram_refresh_done, (i == 4)); else pass_cnt++;
        end
        nop();
        step(1, 0, CMD_ACT, 3, 'h15, '0);
        step(1, 0, CMD_RD, 3, 2, '0);
        chk_cnt++; if (bus.dram_rd_data !== 2'b10) $display("FAIL wr_in_ref_mem: got %b exp 10", bus.dram_rd_data); else pass_cnt++;
    endtask

    task automatic test_clk_en();
        step(1, 0, CMD_PRE, 3, 0, '0);
        step(1, 0, CMD_REF, 0, 0, '0);
        nop();
        for (int i = 0; i < 3; i++) begin
            step(0, 0, CMD_NOP, 0, 0, '0);
            chk_cnt++; if (bus.dram_refresh_done !== 1'b0) $display("FAIL clk_en_hold_%0d: got %b exp 0", i, bus.dram_refresh_done); else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            nop();
            chk_cnt++; if (bus.dram_refresh_done !== (i == 2)) $display("FAIL clk_en_done_%0d: got %b exp %b", i, bus.dram_refresh_done, (i == 2)); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        step(1, 0, CMD_REF, 0, 0, '0);
        nop();
        nop();
        #2 u_rst_n = 0;
        m_reset();
        #1;
        chk_cnt++; if ({bus.dram_rd_data, cmd_err, err_code, bus.dram_refresh_done} !== 7'b0) $display("FAIL reset_mid_outs: got rd=%b err=%b code=%0d done=%b exp 0", bus.dram_rd_data, cmd_err, err_code, bus.dram_refresh_done); else pass_cnt++;
        @(negedge u_clk);
        u_rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            nop();
            chk_cnt++; if (bus.dram_refresh_done !== 1'b0) $display("FAIL reset_mid_done_%0d: got %b exp 0", i, bus.dram_refresh_done); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        step(1, 0, CMD_ACT, 6, 9, '0);
        step(1, 0, CMD_WR, 6, 1, 2'b11);
        step(1, 0, CMD_WR, 6, 3, 2'b01);
        step(1, 0, CMD_RD, 6, 1, '0);
        chk_cnt++; if (bus.dram_rd_data !== 2'b11) $display("FAIL b2b_rd1: got %b exp 11", bus.dram_rd_data); else pass_cnt++;
        step(1, 0, CMD_RD, 6, 3, '0);
        chk_cnt++; if (bus.dram_rd_data !== 2'b01) $display("FAIL b2b_rd3: got %b exp 01", bus.dram_rd_data); else pass_cnt++;
        chk_cnt++; if (cmd_err !== 1'b0) $display("FAIL b2b_err: got %b exp 0", cmd_err); else pass_cnt++;
    endtask

    task automatic test_random();
        int r;
        logic [2:0] c;
        logic [DW-1:0] exp_rd;
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 15) c = CMD_NOP;
            else if (r < 35) c = CMD_PRE;
            else if (r < 55) c = CMD_ACT;
            else if (r < 70) c = CMD_WR;
            else if (r < 85) c = CMD_RD;
            else if (r < 95) c = CMD_REF;
            else             c = ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b110;
            step($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, c,
                 $urandom_range(0, 1), $urandom_range(0, 127), 2'($urandom_range(0, 3)));
            chk_cnt++; if ({cmd_err, err_code} !== {m_err, m_code}) $display("FAIL rand_err_%0d: got err=%b code=%0d exp %b/%0d", i, cmd_err, err_code, m_err, m_code); else pass_cnt++;
            chk_cnt++; if (bus.dram_refresh_done !== m_done) $display("FAIL rand_done_%0d: got %b exp %b", i, bus.dram_refresh_done, m_done); else pass_cnt++;
            if (exp_q.size() > 0) begin
                exp_rd = exp_q.pop_front();
                chk_cnt++; if (bus.dram_rd_data !== exp_rd) $display("FAIL rand_rd_%0d: got %b exp %b", i, bus.dram_rd_data, exp_rd); else pass_cnt++;
            end
        end
    endtask

    task automatic test_stats();
        logic [15:0] e [4];
`ifdef DRAM_DEVICE_MODEL_STATS_EN
        for (int i = 0; i < 4; i++) e[i] = 16'(m_stat[i]);
`else
        for (int i = 0; i < 4; i++) e[i] = 16'(0);
`endif
        chk_cnt++; if (s_act !== e[0]) $display("FAIL stat_act: got %0d exp %0d", s_act, e[0]); else pass_cnt++;
        chk_cnt++; if (s_rd  !== e[1]) $display("FAIL stat_rd: got %0d exp %0d", s_rd, e[1]); else pass_cnt++;
        chk_cnt++; if (s_wr  !== e[2]) $display("FAIL stat_wr: got %0d exp %0d", s_wr, e[2]); else pass_cnt++;
        chk_cnt++; if (s_ref !== e[3]) $display("FAIL stat_ref: got %0d exp %0d", s_ref, e[3]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_act_open();
        test_access_closed();
        test_refresh();
        test_ref_open();
        test_clk_en();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_stats();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
